keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Input-side counterpart to the multiplexed 7-segment display driver: scans a 4x4
//  matrix keypad by driving one row low at a time and reading the column lines.
//  Debounces presses and releases and hands a 4-bit key code to the parking
//  controller (spot selection / mode keys) through a valid/ack handshake.
// PARAMETERS
//  ScanDiv        104165  Clk cycles per row slot (~480 Hz slot rate @ 50 MHz); >= 2
//  DebounceCount  4       consecutive confirming slot ticks for press and release; >= 1
// PORTS
//  Clk      in   1  system clock; all logic on rising edge
//  Reset_n  in   1  synchronous, active-low reset
//  Columns  in   4  keypad column lines, active-low (pulled up), pre-synchronised externally
//  KeyAck   in   1  consumer accepted KeyCode; clears KeyValid
//  Rows     out  4  row drive, active-low one-hot (exactly one bit 0)
//  KeyCode  out  4  {RowIdx[1:0], ColIdx[1:0]} of last confirmed key
//  KeyValid out  1  new key available; held until KeyAck
//  KeyHeld  out  1  confirmed key still pressed (until release debounced)
//  Overrun  out  1  sticky: a key was confirmed while KeyValid was still 1
// BEHAVIOUR
//  Reset (Reset_n=0 at an edge): state SCAN, RowIdx=0, Rows=4'b1110, tick and debounce
//   counters=0, KeyCode=0, KeyValid=0, KeyHeld=0, Overrun=0. Applies in any state.
//  Tick: free-running counter 0..ScanDiv-1; Tick=1 for one Clk when count==ScanDiv-1.
//   Columns sampled only on Tick cycles (end of slot, lines settled).
//  Rows = ~(4'b0001 << RowIdx); RowIdx changes only as stated below.
//  FSM:
//   SCAN: on Tick, if Columns==4'b1111 -> RowIdx+1 (wraps 3->0). Else latch
//    ColIdx = lowest-index low column (priority), DbCnt=1, -> PRESS_DB (row frozen);
//    if DebounceCount==1 go straight to HELD with the confirm actions below.
//   PRESS_DB: on Tick, Columns[ColIdx]==0 -> DbCnt+1; when DbCnt reaches
//    DebounceCount -> confirm, -> HELD. Columns[ColIdx]==1 -> RowIdx+1, -> SCAN
//    (bounce rejected, nothing reported).
//   HELD: KeyHeld=1. On Tick, Columns[ColIdx]==1 -> RelCnt+1, else RelCnt=0;
//    RelCnt reaches DebounceCount -> KeyHeld=0, RowIdx+1, -> SCAN.
//    Other keys pressed while HELD are ignored (no rollover).
//  Confirm (registered, visible next Clk): KeyCode={RowIdx,ColIdx}, KeyValid=1;
//   if KeyValid was already 1 and KeyAck=0 that cycle -> Overrun=1.
//  KeyAck=1 while KeyValid=1 -> KeyValid=0 and Overrun=0 next Clk. KeyAck with
//   KeyValid=0 is ignored. Ack and confirm in the same cycle: confirm wins
//   (KeyValid stays 1, new KeyCode, Overrun unchanged).
//  Latency press->KeyValid: up to 3 ticks waiting for row slot, + DebounceCount-1
//   ticks, + 1 Clk. Release->next detection: DebounceCount ticks.
//  Counters: DbCnt/RelCnt width $clog2(DebounceCount+1), saturate; tick counter
//   width $clog2(ScanDiv).
// STRUCTURE
//  Shared include keypad_defs.vh: FSM state localparams (SCAN, PRESS_DB, HELD),
//   KeyCode field positions, row idle value 4'b1111.
//  One sub-module: scan_tick_gen (#ScanDiv; Clk, Reset_n -> Tick one-cycle enable).
//   Tick is an enable, never a derived clock.
//  Top: FSM, row/column logic, handshake and Overrun registers.
// TESTING (ScanDiv=4, DebounceCount=3 unless noted)
//  1 Reset: hold Reset_n=0 mid-count -> Rows=4'b1110, KeyCode=0, KeyValid=KeyHeld=Overrun=0;
//    release -> Rows rotates 1110,1101,1011,0111,1110 every 4 Clk.
//  2 Press row2/col1 stable (Columns=4'b1101 when Rows=4'b1011) -> KeyCode=4'h9,
//    KeyValid=1 and KeyHeld=1 3 ticks after first detect +1 Clk; KeyValid holds until
//    KeyAck, clears next Clk; KeyHeld drops 3 ticks after release.
//  3 Bounce: row0/col2 low for 1 tick then high -> KeyValid stays 0, scan resumes at row1.
//  4 Row1 with cols 0 and 3 low together -> KeyCode=4'h4.
//  5 Key 4'h9 confirmed, no ack, then 4'h0 pressed/confirmed -> KeyCode=4'h0,
//    Overrun=1; KeyAck -> KeyValid=0, Overrun=0. Ack in same Clk as confirm -> KeyValid
//    stays 1, Overrun stays 0.
//  6 Reset_n=0 for 1 Clk while HELD -> all outputs at reset values next Clk, state SCAN.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scanner_pkg
// Shared definitions for the 4x4 keypad scanner: FSM state encoding, KeyCode
// field positions, the idle (all-high) value of row/column lines, and small
// helpers for row drive and column priority.
// -----------------------------------------------------------------------------
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2
  } state_t;

  // KeyCode = {row_idx, col_idx}
  localparam int KC_COL_LSB = 0;
  localparam int KC_COL_MSB = 1;
  localparam int KC_ROW_LSB = 2;
  localparam int KC_ROW_MSB = 3;

  // Pulled-up lines read all ones when nothing is pressed / no row is driven.
  localparam logic [3:0] LINES_IDLE = 4'b1111;

  // Lowest-index column that reads low; wins when several keys share a row.
  function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Active-low one-hot row drive.
  function automatic logic [3:0] row_drive(input logic [1:0] row_idx);
    return ~(4'b0001 << row_idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_gen.sv
// -----------------------------------------------------------------------------
// keypad_scanner_scan_tick_gen
// Free-running slot timer for the keypad scanner. Counts 0..ScanDiv-1 and
// asserts Tick for the single Clk cycle in which the count is ScanDiv-1.
// Tick is a clock enable for the scanner, never used as a clock.
//
// Ports
//   Clk      in   system clock, rising edge
//   Reset_n  in   synchronous active-low reset (count -> 0)
//   Tick     out  one-cycle enable at the end of each row slot
// -----------------------------------------------------------------------------
module keypad_scanner_scan_tick_gen #(
  parameter int ScanDiv = 104165
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic Tick
);

  localparam int            TW   = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
  localparam logic [TW-1:0] LAST = TW'(ScanDiv - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign Tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one row per slot, debounces press and
// release, and presents a 4-bit key code through a valid/ack handshake.
//
// Ports
//   Clk       in   system clock, rising edge
//   Reset_n   in   synchronous active-low reset
//   Columns   in   [3:0] column lines, active-low, already synchronised
//   KeyAck    in   consumer accepted KeyCode; clears KeyValid
//   Rows      out  [3:0] active-low one-hot row drive
//   KeyCode   out  [3:0] {row, col} of the last confirmed key
//   KeyValid  out  new key available, held until KeyAck
//   KeyHeld   out  confirmed key still pressed (until release debounced)
//   Overrun   out  sticky: a key was confirmed while KeyValid was still set
//
// State      | meaning
// -----------+-------------------------------------------------------------
// SCAN       | rotating rows each slot, looking for any low column
// PRESS_DB   | row frozen, counting consecutive slots the latched column is low
// HELD       | key confirmed, counting consecutive slots the column is high
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int ScanDiv       = 104165,
  parameter int DebounceCount = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] Columns,
  input  logic       KeyAck,
  output logic [3:0] Rows,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic       KeyHeld,
  output logic       Overrun
);

  localparam int            DW     = $clog2(DebounceCount + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DebounceCount);
  localparam logic [DW-1:0] DB_ONE = DW'(1);

  logic          tick;
  state_t        state, state_nxt;
  logic [1:0]    row_idx, row_nxt;
  logic [1:0]    col_idx, col_nxt;
  logic [DW-1:0] db_cnt, db_nxt, db_inc;
  logic [DW-1:0] rel_cnt, rel_nxt, rel_inc;
  logic          confirm;
  logic [3:0]    key_code_q;
  logic          key_valid_q;
  logic          overrun_q;

  keypad_scanner_scan_tick_gen #(
    .ScanDiv (ScanDiv)
  ) u_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Tick    (tick)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= SCAN;
      row_idx <= 2'd0;
      col_idx <= 2'd0;
      db_cnt  <= '0;
      rel_cnt <= '0;
    end else begin
      state   <= state_nxt;
      row_idx <= row_nxt;
      col_idx <= col_nxt;
      db_cnt  <= db_nxt;
      rel_cnt <= rel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    col_nxt   = col_idx;
    db_nxt    = db_cnt;
    rel_nxt   = rel_cnt;
    confirm   = 1'b0;

    // Saturating increments so an oversized count can never wrap to zero.
    db_inc  = (db_cnt  == DB_MAX) ? db_cnt  : db_cnt  + 1'b1;
    rel_inc = (rel_cnt == DB_MAX) ? rel_cnt : rel_cnt + 1'b1;

    if (tick) begin
      unique case (state)
        SCAN: begin
          if (Columns == LINES_IDLE) begin
            row_nxt = row_idx + 2'd1;
          end else begin
            col_nxt = lowest_low_col(Columns);
            db_nxt  = DB_ONE;
            rel_nxt = '0;
            // A single confirming sample is enough when DebounceCount is 1.
            if (DB_ONE == DB_MAX) begin
              confirm   = 1'b1;
              state_nxt = HELD;
            end else begin
              state_nxt = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (!Columns[col_idx]) begin
            db_nxt = db_inc;
            if (db_inc == DB_MAX) begin
              confirm   = 1'b1;
              rel_nxt   = '0;
              state_nxt = HELD;
            end
          end else begin
            row_nxt   = row_idx + 2'd1;
            state_nxt = SCAN;
          end
        end
        HELD: begin
          // Only the confirmed column is watched; other keys cannot roll over.
          if (Columns[col_idx]) begin
            rel_nxt = rel_inc;
            if (rel_inc == DB_MAX) begin
              row_nxt   = row_idx + 2'd1;
              state_nxt = SCAN;
            end
          end else begin
            rel_nxt = '0;
          end
        end
        default: begin
          state_nxt = SCAN;
        end
      endcase
    end
  end

  // Confirm takes priority over an ack landing in the same cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (confirm) begin
      key_code_q[KC_ROW_MSB:KC_ROW_LSB] <= row_idx;
      key_code_q[KC_COL_MSB:KC_COL_LSB] <= col_nxt;
      key_valid_q                       <= 1'b1;
      if (key_valid_q && !KeyAck) overrun_q <= 1'b1;
    end else if (KeyAck && key_valid_q) begin
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end
  end

  assign Rows     = row_drive(row_idx);
  assign KeyCode  = key_code_q;
  assign KeyValid = key_valid_q;
  assign KeyHeld  = (state == HELD);
  assign Overrun  = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner (ScanDiv=4, DebounceCount=3). A keypad
// model turns the pressed-key mask and the DUT row drive into column levels.
// Each expected confirmation is queued when a press is issued; a monitor pops
// and compares whenever KeyHeld rises (a new key has just been confirmed).
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] Columns;
  logic       KeyAck = 1'b0;
  logic [3:0] Rows;
  logic [3:0] KeyCode;
  logic       KeyValid;
  logic       KeyHeld;
  logic       Overrun;

  logic [15:0] pressed = 16'h0000;

  typedef struct {
    logic [3:0] code;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];

  int total  = 0;
  int passed = 0;

  keypad_scanner #(
    .ScanDiv       (4),
    .DebounceCount (3)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Columns  (Columns),
    .KeyAck   (KeyAck),
    .Rows     (Rows),
    .KeyCode  (KeyCode),
    .KeyValid (KeyValid),
    .KeyHeld  (KeyHeld),
    .Overrun  (Overrun)
  );

  always #5 Clk = ~Clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    Columns = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (Rows[r] == 1'b0 && pressed[r*4+c]) Columns[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic expect_key(input logic [3:0] code, input logic ovr);
    exp_t e;
    e.code = code;
    e.ovr  = ovr;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge just after the edge that moved the scan onto row r.
  task automatic wait_row_entry(input int r);
    logic [3:0] target;
    logic [3:0] prev;
    logic       found;
    target = ~(4'b0001 << r);
    prev   = Rows;
    found  = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge Clk);
      if (Rows == target && prev != target) found = 1'b1;
      prev = Rows;
    end
    check($sformatf("row%0d_entry_timeout", r), {31'd0, found}, 32'd1);
  endtask

  task automatic wait_held_fall();
    for (int i = 0; i < 64 && KeyHeld; i++) @(negedge Clk);
    check("held_fall_timeout", {31'd0, KeyHeld}, 32'd0);
  endtask

  task automatic ack_pulse();
    KeyAck = 1'b1;
    @(negedge Clk);
    KeyAck = 1'b0;
  endtask

  // Monitor: a KeyHeld rising edge marks a fresh confirmation.
  logic held_prev = 1'b0;
  always @(negedge Clk) begin
    exp_t e;
    if (KeyHeld === 1'b1 && held_prev == 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_key: code=%0h confirmed with nothing expected", KeyCode);
      end else begin
        e = exp_q.pop_front();
        check("mon_keycode", {28'd0, KeyCode}, {28'd0, e.code});
        check("mon_keyvalid", {31'd0, KeyValid}, 32'd1);
        check("mon_overrun", {31'd0, Overrun}, {31'd0, e.ovr});
      end
    end
    held_prev = (KeyHeld === 1'b1);
  end

  initial begin
    // 1: reset, including a reset applied mid-count
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (6) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    check("rst_rows", {28'd0, Rows}, 32'hE);
    check("rst_keycode", {28'd0, KeyCode}, 32'h0);
    check("rst_valid", {31'd0, KeyValid}, 32'd0);
    check("rst_held", {31'd0, KeyHeld}, 32'd0);
    check("rst_overrun", {31'd0, Overrun}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] exp_rows;
      @(negedge Clk);
      exp_rows = ~(4'b0001 << ((i / 4) % 4));
      check($sformatf("rotate_%0d", i), {28'd0, Rows}, {28'd0, exp_rows});
    end

    // 2: key 9 (row2/col1) stable; latency, hold-until-ack, release debounce
    wait_row_entry(2);
    pressed[9] = 1'b1;
    expect_key(4'h9, 1'b0);
    repeat (11) @(negedge Clk);
    check("k9_valid_before_confirm", {31'd0, KeyValid}, 32'd0);
    @(negedge Clk);
    check("k9_valid_at_confirm", {31'd0, KeyValid}, 32'd1);
    repeat (5) @(negedge Clk);
    pressed[10] = 1'b1;
    check("k9_valid_held_no_ack", {31'd0, KeyValid}, 32'd1);
    ack_pulse();
    check("k9_valid_after_ack", {31'd0, KeyValid}, 32'd0);
    check("k9_held_after_ack", {31'd0, KeyHeld}, 32'd1);
    repeat (2) @(negedge Clk);
    pressed = 16'h0000;
    repeat (11) @(negedge Clk);
    check("k9_held_before_release", {31'd0, KeyHeld}, 32'd1);
    @(negedge Clk);
    check("k9_held_released", {31'd0, KeyHeld}, 32'd0);
    check("k9_rows_after_release", {28'd0, Rows}, 32'h7);

    // 3: bounce on row0/col2 for a single tick
    wait_row_entry(0);
    pressed[2] = 1'b1;
    repeat (4) @(negedge Clk);
    check("bounce_row_frozen", {28'd0, Rows}, 32'hE);
    pressed[2] = 1'b0;
    repeat (4) @(negedge Clk);
    check("bounce_rows_resume", {28'd0, Rows}, 32'hD);
    check("bounce_valid", {31'd0, KeyValid}, 32'd0);
    check("bounce_held", {31'd0, KeyHeld}, 32'd0);

    // 4: row1 with cols 0 and 3 together -> lowest column wins
    wait_row_entry(1);
    pressed[4] = 1'b1;
    pressed[7] = 1'b1;
    expect_key(4'h4, 1'b0);
    repeat (12) @(negedge Clk);
    ack_pulse();
    pressed = 16'h0000;
    wait_held_fall();

    // 5a: unacknowledged key then another confirm -> overrun
    wait_row_entry(2);
    pressed[9] = 1'b1;
    expect_key(4'h9, 1'b0);
    repeat (12) @(negedge Clk);
    pressed = 16'h0000;
    wait_held_fall();
    wait_row_entry(0);
    pressed[0] = 1'b1;
    expect_key(4'h0, 1'b1);
    repeat (12) @(negedge Clk);
    pressed = 16'h0000;
    check("ovr_set", {31'd0, Overrun}, 32'd1);
    wait_held_fall();
    check("ovr_sticky", {31'd0, Overrun}, 32'd1);
    ack_pulse();
    check("ovr_ack_valid", {31'd0, KeyValid}, 32'd0);
    check("ovr_ack_clear", {31'd0, Overrun}, 32'd0);

    // 5b: ack in the same cycle as a confirm -> confirm wins, no overrun
    wait_row_entry(2);
    pressed[9] = 1'b1;
    expect_key(4'h9, 1'b0);
    repeat (12) @(negedge Clk);
    pressed = 16'h0000;
    wait_held_fall();
    wait_row_entry(0);
    pressed[0] = 1'b1;
    expect_key(4'h0, 1'b0);
    repeat (11) @(negedge Clk);
    ack_pulse();
    check("same_cycle_valid", {31'd0, KeyValid}, 32'd1);
    check("same_cycle_code", {28'd0, KeyCode}, 32'h0);
    check("same_cycle_overrun", {31'd0, Overrun}, 32'd0);
    @(negedge Clk);
    check("same_cycle_valid_holds", {31'd0, KeyValid}, 32'd1);
    pressed = 16'h0000;
    wait_held_fall();

    // 6: reset for one Clk while HELD
    wait_row_entry(1);
    pressed[5] = 1'b1;
    expect_key(4'h5, 1'b1);
    repeat (12) @(negedge Clk);
    check("pre_reset_held", {31'd0, KeyHeld}, 32'd1);
    Reset_n = 1'b0;
    pressed = 16'h0000;
    @(negedge Clk);
    Reset_n = 1'b1;
    check("held_rst_rows", {28'd0, Rows}, 32'hE);
    check("held_rst_keycode", {28'd0, KeyCode}, 32'h0);
    check("held_rst_valid", {31'd0, KeyValid}, 32'd0);
    check("held_rst_held", {31'd0, KeyHeld}, 32'd0);
    check("held_rst_overrun", {31'd0, Overrun}, 32'd0);
    repeat (4) @(negedge Clk);
    check("held_rst_scan_resumes", {28'd0, Rows}, 32'hD);

    repeat (4) @(negedge Clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
